dac_mux_scan: RTL and testbench
===============================

DAC_MUX_SCAN -- requirements
Module: dac_mux_scan

Interface
REQ-001 Parameter N_CH, default 8: number of sample-and-hold channels demultiplexed through the analog mux; range 2..16.
REQ-002 Parameter DW, default 12: DAC code width; range 8..14; each code is left-padded with zeros to a 16-bit frame (PD bits = 00).
REQ-003 Parameter SCLK_DIV, default 4: SCLK half-period in clk cycles; minimum 1.
REQ-004 Parameter SETTLE, default 16: clk cycles the mux is held on a channel after its DAC update; minimum 1.
REQ-005 Localparam AW = $clog2(N_CH).
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 en  input  1  1 = run scan; 0 = stop at the next channel boundary.
REQ-009 single  input  1  1 = stop after one full pass over all channels; 0 = scan continuously.
REQ-010 wr_en  input  1  code-register write strobe.
REQ-011 wr_addr  input  AW  channel index for the write.
REQ-012 wr_data  input  DW  code to store.
REQ-013 sclk  output  1  DAC serial clock; idles high.
REQ-014 dout  output  1  DAC serial data, MSB first.
REQ-015 sync_n  output  1  DAC frame sync, active low.
REQ-016 pos  output  AW  analog mux select.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 frame_done  output  1  one-cycle pulse after the last channel's SETTLE completes.

Function
REQ-019 The block SHALL hold an N_CH x DW code register file; wr_en writes reg[wr_addr] <= wr_data on the same edge, in any state.
REQ-020 Writes with wr_addr >= N_CH SHALL be ignored.
REQ-021 FSM states SHALL be IDLE, LOAD, SHIFT, HOLD.
REQ-022 IDLE: sclk=1, sync_n=1, ch=0; when en=1, go to LOAD.
REQ-023 LOAD (1 cycle): latch {zeros, reg[ch]} into a 16-bit shift register; a write to reg[ch] on this same edge is not captured (old value is sent).
REQ-024 SHIFT: sync_n=0 for exactly 32*SCLK_DIV cycles; each bit occupies 2*SCLK_DIV cycles (SCLK_DIV cycles with sclk=1, then SCLK_DIV with sclk=0); dout changes only at bit start; 16 bits total, bit 15 first.
REQ-025 HOLD: sync_n=1, sclk=1, pos=ch from the first HOLD cycle, held for SETTLE cycles.
REQ-026 End of HOLD: if ch=N_CH-1, assert frame_done for one cycle and set ch=0, otherwise ch=ch+1.
REQ-027 End of HOLD: next state is IDLE if en=0, or if single=1 and ch was N_CH-1; otherwise LOAD.
REQ-028 Deasserting en mid-SHIFT SHALL NOT truncate the frame; the current frame and HOLD complete first.
REQ-029 pos SHALL keep its last value in IDLE.
REQ-030 Per-channel period SHALL be 1 + 32*SCLK_DIV + SETTLE cycles.

Reset
REQ-031 On rst, on the next edge: state=IDLE, ch=0, sclk=1, sync_n=1, dout=0, pos=0, busy=0, frame_done=0, all code registers = 0.
REQ-032 rst mid-frame SHALL abort immediately, with no trailing SCLK edge.
REQ-033 rst SHALL take priority over wr_en.

Structure
REQ-034 A shared package dac_pkg SHALL hold the state enum, FRAME_W=16 and the PD field constant.
REQ-035 The serializer SHALL be one sub-module, spi_tx16 (load, SCLK_DIV timing, done pulse), instantiated once; the FSM, register file and mux control live in dac_mux_scan.

Verification (N_CH=8, DW=12, SCLK_DIV=2, SETTLE=4)
REQ-036 Reset, write reg[3]=0xA5C, en=1, single=1: channel 3 frame on dout = 0x0A5C; 8 frames total; frame_done pulses once, 8*(1+64+4)=552 cycles after leaving IDLE; then IDLE.
REQ-037 Continuous scan: pos sequence is 0..7,0,1; each value is held exactly 4+65 cycles; sync_n low 64 cycles per frame; 16 sclk falling edges per frame.
REQ-038 Write reg[2] during channel 2 SHIFT: current frame carries the old code; the next pass carries the new code.
REQ-039 Drop en during channel 5 SHIFT: frame 5 and its HOLD complete; IDLE with pos=5; busy falls.
REQ-040 Assert rst during bit 7 of a frame: the next cycle shows sync_n=1, sclk=1, pos=0; all registers read back 0 on the next pass.
REQ-041 Write with wr_addr=7 and wr_data=0xFFF: frame = 0x0FFF; AW=3, so no out-of-range write is possible at N_CH=8. Repeat with N_CH=6, wr_addr=6: no register changes.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and frame constants for the DAC mux scanner and its serializer.
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  localparam int FRAME_W = 16;

  // Power-down field of the DAC frame: 00 selects normal operation.
  localparam logic [1:0] PD_NORMAL = 2'b00;

endpackage

// File: rtl/dac_mux_scan_spi_tx16.sv
// 16-bit MSB-first serializer: SCLK idles high, data changes at bit start,
// and the DAC samples on the falling edge while sync_n is low.
module spi_tx16
  import dac_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] data,
  output logic               sclk,
  output logic               dout,
  output logic               sync_n,
  output logic               done
);

  localparam int DCW = $clog2(SCLK_DIV + 1);

  logic               active;
  logic               low_half;
  logic [DCW-1:0]     div_cnt;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-2:0] sr;
  logic               half_end;

  assign half_end = (div_cnt == DCW'(SCLK_DIV - 1));
  // Asserted in the last cycle of the frame so the FSM leaves SHIFT on the
  // same edge that releases sync_n.
  assign done     = active && half_end && low_half && (bit_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      low_half <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      sclk     <= 1'b1;
      sync_n   <= 1'b1;
      dout     <= 1'b0;
    end else if (load) begin
      active   <= 1'b1;
      low_half <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sr       <= data[FRAME_W-2:0];
      dout     <= data[FRAME_W-1];
      sclk     <= 1'b1;
      sync_n   <= 1'b0;
    end else if (active) begin
      if (!half_end) begin
        div_cnt <= div_cnt + DCW'(1);
      end else begin
        div_cnt <= '0;
        if (!low_half) begin
          low_half <= 1'b1;
          sclk     <= 1'b0;
        end else if (bit_cnt == 4'd15) begin
          active   <= 1'b0;
          low_half <= 1'b0;
          sclk     <= 1'b1;
          sync_n   <= 1'b1;
          dout     <= 1'b0;
        end else begin
          bit_cnt  <= bit_cnt + 4'd1;
          low_half <= 1'b0;
          sclk     <= 1'b1;
          dout     <= sr[FRAME_W-2];
          sr       <= {sr[FRAME_W-3:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/dac_mux_scan.sv
// Scans N_CH sample-and-hold channels: per channel, send the stored code to the
// DAC, then park the analog mux on that channel for SETTLE cycles.
module dac_mux_scan
  import dac_pkg::*;
#(
  parameter  int N_CH     = 8,
  parameter  int DW       = 12,
  parameter  int SCLK_DIV = 4,
  parameter  int SETTLE   = 16,
  localparam int AW       = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          single,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          sclk,
  output logic          dout,
  output logic          sync_n,
  output logic [AW-1:0] pos,
  output logic          busy,
  output logic          frame_done
);

  localparam int HW = $clog2(SETTLE + 1);

  state_e             state, state_nx;
  logic [DW-1:0]      regs [N_CH];
  logic [AW-1:0]      ch;
  logic [HW-1:0]      hold_cnt;
  logic [FRAME_W-1:0] frame;
  logic               load, tx_done, hold_end, last_ch;

  assign load     = (state == ST_LOAD);
  assign hold_end = (state == ST_HOLD) && (hold_cnt == HW'(SETTLE - 1));
  assign last_ch  = (ch == AW'(N_CH - 1));
  assign busy     = (state != ST_IDLE);

  always_comb begin
    frame                   = '0;
    frame[DW-1:0]           = regs[ch];
    frame[FRAME_W-1 -: 2]   = PD_NORMAL;
  end

  // Addresses past N_CH exist only when N_CH is not a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) regs[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(N_CH))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  spi_tx16 #(
    .SCLK_DIV (SCLK_DIV)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .data   (frame),
    .sclk   (sclk),
    .dout   (dout),
    .sync_n (sync_n),
    .done   (tx_done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (en) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_SHIFT;
      ST_SHIFT: if (tx_done) state_nx = ST_HOLD;
      ST_HOLD: begin
        if (hold_end) state_nx = (!en || (single && last_ch)) ? ST_IDLE : ST_LOAD;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ch         <= '0;
      pos        <= '0;
      hold_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= hold_end && last_ch;
      case (state)
        ST_IDLE: ch <= '0;
        ST_SHIFT: begin
          if (tx_done) begin
            pos      <= ch;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_end) ch <= last_ch ? '0 : ch + AW'(1);
          else          hold_cnt <= hold_cnt + HW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_mux_scan.sv
// Directed bench for dac_mux_scan at N_CH=8/6, DW=12, SCLK_DIV=2, SETTLE=4.
module tb_dac_mux_scan;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst, en, single, wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          sclk, dout, sync_n, busy, frame_done;
  logic [2:0]    pos;
  logic          sclk6, dout6, sync_n6, busy6, frame_done6;
  logic [2:0]    pos6;

  logic          sel6 = 1'b0;
  logic          m_sclk, m_dout, m_sync_n, m_busy, m_frame_done;
  logic [2:0]    m_pos;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int fd_cnt = 0;

  logic [15:0] fq[$];
  int          pq[$], nfq[$], nlq[$], pcv[$], pct[$];
  logic [15:0] exp_f [16];
  int          exp_p [16];

  logic [15:0] sh;
  int          nf, nl;
  logic        p_sync = 1'b1, p_sclk = 1'b1;
  logic [2:0]  p_pos = 3'd0;

  dac_mux_scan #(.N_CH(8), .DW(DW), .SCLK_DIV(2), .SETTLE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .single(single), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .sclk(sclk), .dout(dout),
    .sync_n(sync_n), .pos(pos), .busy(busy), .frame_done(frame_done));

  dac_mux_scan #(.N_CH(6), .DW(DW), .SCLK_DIV(2), .SETTLE(4)) dut6 (
    .clk(clk), .rst(rst), .en(en), .single(single), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .sclk(sclk6), .dout(dout6),
    .sync_n(sync_n6), .pos(pos6), .busy(busy6), .frame_done(frame_done6));

  assign m_sclk       = sel6 ? sclk6 : sclk;
  assign m_dout       = sel6 ? dout6 : dout;
  assign m_sync_n     = sel6 ? sync_n6 : sync_n;
  assign m_busy       = sel6 ? busy6 : busy;
  assign m_frame_done = sel6 ? frame_done6 : frame_done;
  assign m_pos        = sel6 ? pos6 : pos;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame capture: bits taken on SCLK falling edges while sync_n is low.
  always @(negedge clk) begin
    if (!m_sync_n && p_sync) begin sh = '0; nf = 0; nl = 0; end
    if (!m_sync_n) begin
      nl++;
      if (p_sclk && !m_sclk) begin sh = {sh[14:0], m_dout}; nf++; end
    end
    if (m_sync_n && !p_sync) begin
      fq.push_back(sh); pq.push_back(int'(m_pos)); nfq.push_back(nf); nlq.push_back(nl);
    end
    if (m_frame_done === 1'b1) fd_cnt++;
    if (m_pos != p_pos) begin pcv.push_back(int'(m_pos)); pct.push_back(cyc); end
    p_sync = m_sync_n; p_sclk = m_sclk; p_pos = m_pos;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; single = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_q();
    fq.delete(); pq.delete(); nfq.delete(); nlq.delete(); pcv.delete(); pct.delete();
  endtask

  task automatic check_frames(input string tag, input int n);
    check({tag, "_nframes"}, fq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < fq.size()) begin
        check($sformatf("%s_frame%0d", tag, i), int'(fq[i]), int'(exp_f[i]));
        check($sformatf("%s_pos%0d", tag, i), pq[i], exp_p[i]);
        check($sformatf("%s_falls%0d", tag, i), nfq[i], 16);
        check($sformatf("%s_synclow%0d", tag, i), nlq[i], 64);
      end
    end
  endtask

  task automatic run_pass(input string tag, input int exp_dt);
    int  t0, dt;
    bit  ok;
    fd_cnt = 0; single = 1'b1; en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (m_busy === 1'b1) begin ok = 1'b1; break; end
    end
    check({tag, "_start"}, int'(ok), 1);
    t0 = cyc; ok = 1'b0;
    for (int i = 0; i < exp_dt + 100; i++) begin
      tick(1);
      if (m_frame_done === 1'b1) begin ok = 1'b1; break; end
    end
    dt = cyc - t0;
    en = 1'b0;
    check({tag, "_done_seen"}, int'(ok), 1);
    check({tag, "_latency"}, dt, exp_dt);
    check({tag, "_idle_at_done"}, int'(m_busy), 0);
    tick(5);
    check({tag, "_done_pulses"}, fd_cnt, 1);
    check({tag, "_idle_after"}, int'(m_busy), 0);
  endtask

  initial begin
    bit ok;

    do_reset();
    check("rst_sclk", int'(sclk), 1);
    check("rst_sync_n", int'(sync_n), 1);
    check("rst_dout", int'(dout), 0);
    check("rst_pos", int'(pos), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);

    // Single pass with two codes loaded.
    wr(3'd3, 12'hA5C);
    wr(3'd7, 12'hFFF);
    clear_q();
    run_pass("single", 552);
    check("single_pos_parked", int'(pos), 7);
    for (int i = 0; i < 8; i++) begin exp_f[i] = 16'h0000; exp_p[i] = i; end
    exp_f[3] = 16'h0A5C; exp_f[7] = 16'h0FFF;
    check_frames("single", 8);

    // Continuous scan, mid-SHIFT write to ch2, then stop during ch5 SHIFT.
    clear_q();
    single = 1'b0; en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (pos == 3'd1) begin ok = 1'b1; break; end
    end
    check("scan_reach_ch1", int'(ok), 1);
    tick(25);
    wr(3'd2, 12'h123);
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      tick(1);
      if (fq.size() >= 13) begin ok = 1'b1; break; end
    end
    check("scan_reach_ch4", int'(ok), 1);
    tick(25);
    en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    check("stop_busy_fell", int'(ok), 1);
    check("stop_pos", int'(pos), 5);
    tick(3);
    check("stop_still_idle", int'(busy), 0);
    for (int i = 0; i < 14; i++) begin exp_f[i] = 16'h0000; exp_p[i] = i % 8; end
    exp_f[3] = 16'h0A5C; exp_f[7] = 16'h0FFF; exp_f[10] = 16'h0123; exp_f[11] = 16'h0A5C;
    check_frames("scan", 14);
    check("scan_pos_changes", int'(pcv.size() >= 11), 1);
    for (int i = 0; i < 10; i++) begin
      if (i + 1 < pcv.size()) begin
        check($sformatf("scan_posval%0d", i), pcv[i], i % 8);
        check($sformatf("scan_posdur%0d", i), pct[i+1] - pct[i], 69);
      end
    end

    // Reset during bit 7 of channel 0; the concurrent write must lose.
    single = 1'b0; en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (sync_n === 1'b0) begin ok = 1'b1; break; end
    end
    check("abort_frame_started", int'(ok), 1);
    tick(29);
    rst = 1'b1; en = 1'b0; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 12'h777;
    tick(1);
    check("abort_sync_n", int'(sync_n), 1);
    check("abort_sclk", int'(sclk), 1);
    check("abort_pos", int'(pos), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_dout", int'(dout), 0);
    rst = 1'b0; wr_en = 1'b0;
    tick(2);
    clear_q();
    run_pass("after_rst", 552);
    for (int i = 0; i < 8; i++) begin exp_f[i] = 16'h0000; exp_p[i] = i; end
    check_frames("after_rst", 8);

    // N_CH=6 instance: address 6 is out of range and must be dropped.
    sel6 = 1'b1;
    do_reset();
    wr(3'd6, 12'hABC);
    wr(3'd5, 12'h555);
    tick(2);
    clear_q();
    run_pass("nch6", 414);
    for (int i = 0; i < 6; i++) begin exp_f[i] = 16'h0000; exp_p[i] = i; end
    exp_f[5] = 16'h0555;
    check_frames("nch6", 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
